rr_grant_fsm: RTL and testbench
===============================

RR_GRANT_FSM -- requirements
Module: rr_grant_fsm

Interface
REQ-001 Parameter NCH, default 4, number of requesting channels (2..16).
REQ-002 Parameter HOLD_MAX, default 8, maximum grant duration in cycles (2..255).
REQ-003 Parameter IDW, default $clog2(NCH), width of the grant index.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  NCH  per-channel request level; bit i is channel i.
REQ-007 done  in  1  current owner releases its grant.
REQ-008 grant  out  NCH  registered one-hot grant; all-zero when there is no owner.
REQ-009 grant_id  out  IDW  index of the current owner; 0 when grant is all-zero.
REQ-010 busy  out  1  high exactly while grant is non-zero.
REQ-011 timeout  out  1  one-cycle pulse when a grant is revoked at HOLD_MAX.
REQ-012 err  out  1  sticky flag; set when an illegal state encoding is detected.

Function
REQ-013 The FSM SHALL have states IDLE and BUSY, encoded in 2 bits; encodings 2 and 3 are illegal.
REQ-014 IDLE: if req is non-zero at edge t, the FSM SHALL go to BUSY, and grant SHALL show the winner from t+1.
REQ-015 Winner = first set req bit at or after ptr, scanning upward and wrapping from NCH-1 to 0.
REQ-016 On a grant to channel k, ptr SHALL become (k+1) mod NCH.
REQ-017 IDLE with req all-zero SHALL remain IDLE, with grant, ptr and the hold counter unchanged.
REQ-018 BUSY: the hold counter SHALL start at 0 on the grant cycle and increment once per BUSY cycle.
REQ-019 BUSY release conditions, evaluated each edge: done=1, or req[owner]=0, or counter = HOLD_MAX-1.
REQ-020 On release, the FSM SHALL enter IDLE and grant SHALL be zero on the next cycle.
REQ-021 Every release SHALL give at least one all-zero grant cycle between owners; no back-to-back grants.
REQ-022 timeout SHALL pulse in the first cycle after release, only when the counter limit alone caused the release.
REQ-023 If done=1 on the same edge as the counter limit, the release counts as normal and timeout SHALL stay 0.
REQ-024 Changes on non-owner req bits during BUSY SHALL have no effect.
REQ-025 An illegal state SHALL go to IDLE on the next edge, clear grant, and set err.
REQ-026 err SHALL be cleared only by rst.
REQ-027 All next-state and winner logic SHALL be fully specified: every case has a default, every branch assigns every signal, no latches, one driver per signal.

Reset
REQ-028 When rst is asserted, at any time including mid-grant, the block SHALL immediately set: state=IDLE, grant=0, grant_id=0, busy=0, timeout=0, err=0, ptr=0, counter=0.
REQ-029 On the first edge after rst deasserts, the block SHALL perform normal IDLE arbitration.

Structure
REQ-030 The state encoding (IDLE=2'b00, BUSY=2'b01) SHALL live in the shared package rr_pkg, with the illegal encodings listed as constants.
REQ-031 Winner selection SHALL be a purely combinational sub-module, rr_pick, with parameter NCH, inputs req and ptr, and outputs valid, idx and onehot.
REQ-032 Counter width SHALL be $clog2(HOLD_MAX).
REQ-033 Arithmetic on ptr SHALL wrap explicitly when NCH is not a power of two.

Verification
REQ-034 Bench SHALL use NCH=4, HOLD_MAX=8 unless a scenario states otherwise.
REQ-035 Scenario 1: req=4'b0101 held, done pulsed 2 cycles after each grant -> grant sequence 0001, 0000, 0100, 0000, 0001, with one idle cycle between grants.
REQ-036 Scenario 2: req=4'b0010 held, no done -> grant=0010 for exactly 8 cycles, then 0000 with timeout=1 for one cycle, then re-grant to 0010.
REQ-037 Scenario 3: done=1 on the 8th BUSY cycle -> release with timeout=0.
REQ-038 Scenario 4: NCH=3, ptr at 2, req=3'b011 -> wrap gives grant to channel 0, then ptr=1.
REQ-039 Scenario 5: rst asserted mid-grant, asynchronous to clk -> grant=0 and busy=0 immediately; after release, req=4'b1000 -> grant to channel 3 one edge after rst deasserts.
REQ-040 Scenario 6: force state to 2'b11 -> IDLE and err=1 next edge; err stays 1 until rst.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin grant FSM: state encoding and pointer wrap helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rr_pkg;

  // Legal FSM states. The remaining 2-bit codes are illegal and are listed below.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01
  } state_e;

  localparam logic [1:0] ST_ILLEGAL_2 = 2'b10;
  localparam logic [1:0] ST_ILLEGAL_3 = 2'b11;

  // Next channel after idx in an n-channel ring. The wrap is explicit so that
  // non-power-of-two channel counts never leave the legal index range.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: first set req bit at or after ptr, wrapping NCH-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; result follows req/ptr.
// Ports: req (per-channel request), ptr (scan start), valid (any request),
//        idx (winning channel), onehot (winning channel as one-hot, zero if !valid).
module rr_pick #(
  parameter int NCH = 4,
  parameter int IDW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx,
  output logic [NCH-1:0] onehot
);

  always_comb begin
    int cand;
    cand   = 0;
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    // Walk the ring starting at ptr; the first hit wins and later hits are ignored.
    for (int off = 0; off < NCH; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NCH) begin
        cand = cand - NCH;
      end
      if (!valid && req[IDW'(cand)]) begin
        valid = 1'b1;
        idx   = IDW'(cand);
      end
    end
    if (valid) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_fsm.sv
// Round-robin grant FSM: one owner at a time, released on done, request drop or HOLD_MAX cycles.
// Latency: grant visible one edge after a request is seen in IDLE; one all-zero cycle between owners.
// Backpressure: level handshake only; requesters hold req until granted, owner pulses done to release.
// Ports: clk, rst (async, active-high), req[NCH], done -> grant[NCH] (registered one-hot),
//        grant_id, busy (grant non-zero), timeout (pulse on HOLD_MAX revoke), err (sticky illegal state).
module rr_grant_fsm
  import rr_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int HOLD_MAX = 8,
  parameter int IDW      = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           done,
  output logic [NCH-1:0] grant,
  output logic [IDW-1:0] grant_id,
  output logic           busy,
  output logic           timeout,
  output logic           err
);

  localparam int            CW       = $clog2(HOLD_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  state_e         state_q,    state_d;
  logic [NCH-1:0] grant_q,    grant_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] ptr_q,      ptr_d;
  logic [CW-1:0]  cnt_q,      cnt_d;
  logic           timeout_q,  timeout_d;
  logic           err_q,      err_d;

  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic [NCH-1:0] pick_onehot;

  rr_pick #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_vld),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  logic state_illegal;
  logic owner_req;
  logic at_limit;

  always_comb begin
    state_illegal = (state_q == ST_ILLEGAL_2) || (state_q == ST_ILLEGAL_3);
    owner_req     = req[grant_id_q];
    at_limit      = (cnt_q == CNT_LAST);

    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    err_d      = err_q;

    if (state_illegal) begin
      // Recover to a clean idle and remember that it happened.
      state_d    = ST_IDLE;
      grant_d    = '0;
      grant_id_d = '0;
      cnt_d      = '0;
      err_d      = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_d    = ST_BUSY;
            grant_d    = pick_onehot;
            grant_id_d = pick_idx;
            ptr_d      = IDW'(wrap_inc(int'(pick_idx), NCH));
            cnt_d      = '0;
          end
        end
        ST_BUSY: begin
          if (done || !owner_req || at_limit) begin
            state_d    = ST_IDLE;
            grant_d    = '0;
            grant_id_d = '0;
            cnt_d      = '0;
            // Only a revoke forced purely by the hold limit is a timeout;
            // a voluntary release on the same edge wins.
            timeout_d  = at_limit && !done && owner_req;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          grant_d    = '0;
          grant_id_d = '0;
          cnt_d      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = |grant_q;
  assign timeout  = timeout_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rr_grant_fsm.sv
// Self-checking bench for rr_grant_fsm (NCH=4 main instance, NCH=3 instance for wrap).
// Latency: n/a. Backpressure: n/a.
module tb_rr_grant_fsm;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       busy;
    logic       to;
    logic       err;
  } obs_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;
  logic       err;

  logic [2:0] req3;
  logic       done3;
  logic [2:0] grant3;
  logic [1:0] grant_id3;
  logic       busy3;
  logic       timeout3;
  logic       err3;

  int   n_cmp;
  int   n_bad;
  obs_t sb[$];

  rr_grant_fsm #(.NCH(4), .HOLD_MAX(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout),
    .err      (err)
  );

  rr_grant_fsm #(.NCH(3), .HOLD_MAX(8)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .req      (req3),
    .done     (done3),
    .grant    (grant3),
    .grant_id (grant_id3),
    .busy     (busy3),
    .timeout  (timeout3),
    .err      (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observation; busy is high exactly when grant is non-zero.
  function automatic obs_t exp_of(input logic [3:0] g, input logic [1:0] id,
                                  input logic to, input logic e);
    return {g, id, |g, to, e};
  endfunction

  function automatic obs_t cap_main();
    return {grant, grant_id, busy, timeout, err};
  endfunction

  function automatic obs_t cap_n3();
    return {1'b0, grant3, grant_id3, busy3, timeout3, err3};
  endfunction

  task automatic test_reset();
    obs_t act, exp;
    rst = 1'b0; req = '0; done = 1'b0; req3 = '0; done3 = 1'b0;
    #2 rst = 1'b1;
    #1;
    sb.push_back(exp_of(4'b0000, 2'd0, 1'b0, 1'b0));
    act = cap_main(); exp = sb.pop_front(); n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL reset_main: got {g,id,busy,to,err}=%b want %b", act, exp);
    end
    sb.push_back(exp_of(4'b0000, 2'd0, 1'b0, 1'b0));
    act = cap_n3(); exp = sb.pop_front(); n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL reset_n3: got {g,id,busy,to,err}=%b want %b", act, exp);
    end
    // Requests present while reset is held must not be granted.
    req = 4'b1111;
    sb.push_back(exp_of(4'b0000, 2'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    act = cap_main(); exp = sb.pop_front(); n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL reset_held: got {g,id,busy,to,err}=%b want %b", act, exp);
    end
    req = '0;
    rst = 1'b0;
  endtask

  // req=0101 held, done two cycles into each grant: 0001,0000,0100,0000,0001.
  task automatic test_alternate();
    logic [3:0] rq [8]  = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000};
    logic       dn [8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] eg [8]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0000};
    logic [1:0] eid [8] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0};
    obs_t act, exp;
    for (int k = 0; k < 8; k++) begin
      req = rq[k]; done = dn[k];
      sb.push_back(exp_of(eg[k], eid[k], 1'b0, 1'b0));
      @(posedge clk); #1;
      act = cap_main(); exp = sb.pop_front(); n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL alternate step %0d: got {g,id,busy,to,err}=%b want %b", k, act, exp);
      end
    end
    done = 1'b0;
  endtask

  // req=0010 held with no done: 8 grant cycles, one timeout cycle, re-grant.
  task automatic test_timeout();
    obs_t act, exp;
    for (int k = 0; k < 11; k++) begin
      req = (k < 10) ? 4'b0010 : 4'b0000;
      done = 1'b0;
      if (k < 8)       sb.push_back(exp_of(4'b0010, 2'd1, 1'b0, 1'b0));
      else if (k == 8) sb.push_back(exp_of(4'b0000, 2'd0, 1'b1, 1'b0));
      else if (k == 9) sb.push_back(exp_of(4'b0010, 2'd1, 1'b0, 1'b0));
      else             sb.push_back(exp_of(4'b0000, 2'd0, 1'b0, 1'b0));
      @(posedge clk); #1;
      act = cap_main(); exp = sb.pop_front(); n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL timeout step %0d: got {g,id,busy,to,err}=%b want %b", k, act, exp);
      end
    end
  endtask

  // done coincides with the hold limit: normal release, no timeout.
  // Non-owner request bits toggle randomly while busy and must be ignored.
  task automatic test_done_at_limit();
    obs_t act, exp;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      req = 4'b0100;
      else if (k < 9)  req = 4'b0100 | (4'($urandom) & 4'b1011);
      else             req = 4'b0000;
      done = (k == 8);
      if (k < 8) sb.push_back(exp_of(4'b0100, 2'd2, 1'b0, 1'b0));
      else       sb.push_back(exp_of(4'b0000, 2'd0, 1'b0, 1'b0));
      @(posedge clk); #1;
      act = cap_main(); exp = sb.pop_front(); n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL done_at_limit step %0d: got {g,id,busy,to,err}=%b want %b", k, act, exp);
      end
    end
    done = 1'b0;
  endtask

  // NCH=3: move ptr to 2, then req=011 wraps to channel 0, after which ptr=1 picks channel 1.
  task automatic test_wrap();
    logic [2:0] rq [6]  = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b011, 3'b000};
    logic       dn [6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] eg [6]  = '{4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    logic [1:0] eid [6] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
    obs_t act, exp;
    for (int k = 0; k < 6; k++) begin
      req3 = rq[k]; done3 = dn[k];
      sb.push_back(exp_of(eg[k], eid[k], 1'b0, 1'b0));
      @(posedge clk); #1;
      act = cap_n3(); exp = sb.pop_front(); n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL wrap step %0d: got {g,id,busy,to,err}=%b want %b", k, act, exp);
      end
    end
    done3 = 1'b0;
  endtask

  // Reset asserted between edges while a grant is held.
  task automatic test_async_reset();
    obs_t act, exp;
    req = 4'b0001;
    sb.push_back(exp_of(4'b0001, 2'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    act = cap_main(); exp = sb.pop_front(); n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL arst_pre_grant: got {g,id,busy,to,err}=%b want %b", act, exp);
    end
    #3 rst = 1'b1;
    sb.push_back(exp_of(4'b0000, 2'd0, 1'b0, 1'b0));
    #1;
    act = cap_main(); exp = sb.pop_front(); n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL arst_immediate: got {g,id,busy,to,err}=%b want %b", act, exp);
    end
    sb.push_back(exp_of(4'b0000, 2'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    act = cap_main(); exp = sb.pop_front(); n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL arst_held: got {g,id,busy,to,err}=%b want %b", act, exp);
    end
    #3 rst = 1'b0;
    req = 4'b1000;
    sb.push_back(exp_of(4'b1000, 2'd3, 1'b0, 1'b0));
    @(posedge clk); #1;
    act = cap_main(); exp = sb.pop_front(); n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL arst_first_grant: got {g,id,busy,to,err}=%b want %b", act, exp);
    end
    req = 4'b0000;
    sb.push_back(exp_of(4'b0000, 2'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    act = cap_main(); exp = sb.pop_front(); n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL arst_release: got {g,id,busy,to,err}=%b want %b", act, exp);
    end
  endtask

  // Corrupt the state register mid-grant; expect idle + sticky err until reset.
  task automatic test_illegal();
    logic [1:0] bad_state;
    logic [3:0] rq [4]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    logic [3:0] eg [4]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000};
    obs_t act, exp;
    bad_state = rr_pkg::ST_ILLEGAL_3;
    req = 4'b0001;
    sb.push_back(exp_of(4'b0001, 2'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    act = cap_main(); exp = sb.pop_front(); n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL illegal_pre_grant: got {g,id,busy,to,err}=%b want %b", act, exp);
    end
    force dut.state_q = rr_pkg::state_e'(bad_state);
    #1 release dut.state_q;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) req = rq[k];
      sb.push_back(exp_of(eg[k], 2'd0, 1'b0, 1'b1));
      @(posedge clk); #1;
      act = cap_main(); exp = sb.pop_front(); n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL illegal step %0d: got {g,id,busy,to,err}=%b want %b", k, act, exp);
      end
    end
    rst = 1'b1;
    sb.push_back(exp_of(4'b0000, 2'd0, 1'b0, 1'b0));
    #1;
    act = cap_main(); exp = sb.pop_front(); n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL illegal_err_clear: got {g,id,busy,to,err}=%b want %b", act, exp);
    end
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_alternate();
    test_timeout();
    test_done_at_limit();
    test_wrap();
    test_async_reset();
    test_illegal();
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
